sipo_rotate_rx: RTL and testbench

SIPO_ROTATE_RX -- requirements
Module: sipo_rotate_rx

---
 rtl/sipo_rotate_rx.sv | 96 +++++++++
 tb/tb_sipo_rotate_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sipo_rotate_rx.sv
// Serial-in, parallel-out receiver for an LSB-first stream from a right-rotate transmitter.
// Frames begin on start, finish after DW enabled bits; a start mid-frame aborts and restarts.
module sipo_rotate_rx #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic          start,
    input  logic          en,
    input  logic          sin,
    output logic [DW-1:0] q,
    output logic          valid,
    output logic          busy,
    output logic          err
);

    localparam int CW = (DW > 2) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [DW-1:0] sr, sr_nx;
    logic [DW-1:0] q_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          valid_nx, err_nx;
    logic [DW-1:0] shifted;
    logic [DW-1:0] first_bit;

    // Bits enter at the MSB so bit 0 of the frame lands in sr[0] after DW shifts.
    assign shifted   = {sin, sr[DW-1:1]};
    assign first_bit = {sin, {(DW-1){1'b0}}};

    // NOTE: every next-value signal is defaulted before the decode so no path infers a latch.
    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = cnt;
        q_nx     = q;
        valid_nx = 1'b0;
        err_nx   = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sr_nx    = first_bit;
                        cnt_nx   = CW'(1);
                        state_nx = RECV;
                    end
                end
                RECV: begin
                    if (start) begin
                        // Restart: the partial word is dropped and q is left untouched.
                        sr_nx  = first_bit;
                        cnt_nx = CW'(1);
                        err_nx = 1'b1;
                    end else if (cnt == LAST) begin
                        sr_nx    = shifted;
                        q_nx     = shifted;
                        valid_nx = 1'b1;
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end else begin
                        sr_nx  = shifted;
                        cnt_nx = cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            q     <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            sr    <= sr_nx;
            cnt   <= cnt_nx;
            q     <= q_nx;
            valid <= valid_nx;
            err   <= err_nx;
            busy  <= (state_nx == RECV);
        end
    end

endmodule

// File: tb/tb_sipo_rotate_rx.sv
// Directed and randomized checks of sipo_rotate_rx against a bit-queue reference model.
module tb_sipo_rotate_rx;

    localparam int DW = 4;

    logic          clk;
    logic          sync_rst;
    logic          start;
    logic          en;
    logic          sin;
    logic [DW-1:0] q;
    logic          valid;
    logic          busy;
    logic          err;

    int tests = 0;
    int fails = 0;

    // Reference model: the current frame is just a list of received bits.
    bit            m_bits[$];
    logic [DW-1:0] m_q;
    logic          m_valid;
    logic          m_err;
    logic          m_busy;

    sipo_rotate_rx #(.DW(DW)) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .start    (start),
        .en       (en),
        .sin      (sin),
        .q        (q),
        .valid    (valid),
        .busy     (busy),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic st, input logic e, input logic s);
        if (r) begin
            m_bits.delete();
            m_q     = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else begin
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (e) begin
                if (st) begin
                    if (m_bits.size() != 0) m_err = 1'b1;
                    m_bits.delete();
                    m_bits.push_back(s);
                end else if (m_bits.size() != 0) begin
                    m_bits.push_back(s);
                    if (m_bits.size() == DW) begin
                        m_q = '0;
                        for (int i = 0; i < DW; i++) m_q = m_q + (DW'(m_bits[i]) << i);
                        m_valid = 1'b1;
                        m_bits.delete();
                    end
                end
            end
        end
        m_busy = (m_bits.size() != 0);
    endtask

    // Apply one cycle of inputs, advance past the edge, and compare every output with the model.
    task automatic step(input logic r, input logic st, input logic e, input logic s);
        sync_rst = r;
        start    = st;
        en       = e;
        sin      = s;
        @(posedge clk);
        #1;
        model_step(r, st, e, s);
        chk("q",     32'(q),     32'(m_q));
        chk("valid", 32'(valid), 32'(m_valid));
        chk("busy",  32'(busy),  32'(m_busy));
        chk("err",   32'(err),   32'(m_err));
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        for (int b = 0; b < DW; b++) step(1'b0, b == 0, 1'b1, w[b]);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] tx;

        sync_rst = 1'b0;
        start    = 1'b0;
        en       = 1'b0;
        sin      = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Idle enabled bits without start are ignored
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("idle_ignore_busy", 32'(busy), 32'h0);

        // Basic frame 1,1,0,1 -> B
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("basic_no_partial_q", 32'(q), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("basic_q", 32'(q), 32'hB);
        chk("basic_valid", 32'(valid), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("basic_valid_drop", 32'(valid), 32'h0);
        chk("basic_busy_low", 32'(busy), 32'h0);

        // Gap of two disabled cycles, plus a reset glitch between edges
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("gap_busy", 32'(busy), 32'h1);
        sync_rst = 1'b1;
        #2;
        sync_rst = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("gap_q", 32'(q), 32'hB);
        chk("gap_valid", 32'(valid), 32'h1);

        // Abort: 3 bits of 6, then restart with 5
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("abort_err", 32'(err), 32'h1);
        chk("abort_q_held", 32'(q), 32'hB);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("abort_err_drop", 32'(err), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("abort_q", 32'(q), 32'h5);

        // Mid-frame reset, with start/en/sin also active on the reset edge
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("midrst_busy", 32'(busy), 32'h0);
        for (int i = 0; i < DW; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("midrst_q", 32'(q), 32'h0);
        send_word(4'hF);
        chk("midrst_next_q", 32'(q), 32'hF);

        // Back-to-back frames 9 then 3
        send_word(4'h9);
        chk("b2b_q0", 32'(q), 32'h9);
        chk("b2b_v0", 32'(valid), 32'h1);
        send_word(4'h3);
        chk("b2b_q1", 32'(q), 32'h3);
        chk("b2b_v1", 32'(valid), 32'h1);

        // Random traffic, including aborts, gaps and resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom));
        end

        // Loopback from a right-rotate transmitter
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int w = 0; w < 50; w++) begin
            d  = DW'($urandom);
            tx = d;
            for (int b = 0; b < DW; b++) begin
                step(1'b0, b == 0, 1'b1, tx[0]);
                tx = {tx[0], tx[DW-1:1]};
            end
            chk("loop_q", 32'(q), 32'(d));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
